// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: owns the imem write port during LOAD and the PC during RUN.
// Optional load checksum register is built when IMEM_LOAD_CHECKSUM_EN is defined.
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 256,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        run_start,
   input  logic        halt_req,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        imem_we,
   output logic [7:0]  imem_waddr,
   output logic [31:0] imem_wdata,
   output logic [31:0] pc,
   output logic        fetch_valid,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic [1:0]  state,
   output logic [8:0]  load_count,
   output logic        load_err,
   output logic [31:0] load_csum
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [8:0] FULL_CNT = 9'(DEPTH);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        enter_load;
   logic        xfer;

   assign load_ready  = (state_q == S_LOAD);
   assign xfer        = load_valid & load_ready;
   assign imem_we     = xfer;
   assign imem_waddr  = load_ready ? cnt_q[7:0] : 8'd0;
   assign imem_wdata  = load_ready ? load_data : 32'd0;
   assign fetch_valid = (state_q == S_RUN);
   assign state       = state_q;
   assign pc          = pc_q;
   assign load_count  = cnt_q;
   assign load_err    = err_q;

   // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      enter_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start)     enter_load = 1'b1;
            else if (run_start) state_d    = S_RUN;
         end
         S_LOAD: begin
            if (xfer) begin
               cnt_d = cnt_q + 9'd1;
               if (load_last) begin
                  state_d = S_RUN;
               end else if (cnt_q + 9'd1 == FULL_CNT) begin
                  // Full memory without a last word: abort rather than wrap to address 0.
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_RUN: begin
            if (load_start)        enter_load = 1'b1;
            else if (halt_req)     state_d    = S_HALT;
            else if (stall)        pc_d       = pc_q;
            else if (branch_taken) pc_d       = branch_target & 32'hFFFF_FFFC;
            else                   pc_d       = pc_q + 32'd4;
         end
         S_HALT: begin
            if (load_start)     enter_load = 1'b1;
            else if (run_start) state_d    = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
      if (enter_load) begin
         state_d = S_LOAD;
         pc_d    = RESET_PC;
         cnt_d   = 9'd0;
         err_d   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= 9'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          csum_q <= 32'd0;
      else if (enter_load) csum_q <= 32'd0;
      else if (xfer)       csum_q <= csum_q ^ load_data;
   end

   assign load_csum = csum_q;
`else
   assign load_csum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl: load, throttled load, PC sequencing,
// halt/resume, overflow and mid-load reset.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start, run_start, halt_req;
   logic        load_valid, load_last;
   logic [31:0] load_data;
   logic        load_ready, imem_we;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata, pc;
   logic        fetch_valid;
   logic        branch_taken, stall;
   logic [31:0] branch_target;
   logic [1:0]  state;
   logic [8:0]  load_count;
   logic        load_err;
   logic [31:0] load_csum;

   int n_cmp = 0;
   int n_bad = 0;

   imem_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .run_start(run_start), .halt_req(halt_req),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .pc(pc), .fetch_valid(fetch_valid),
      .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
      .state(state), .load_count(load_count), .load_err(load_err), .load_csum(load_csum)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] words [11] = '{32'h8c010000, 32'h8c020004, 32'h00221820, 32'hac030008,
                               32'h8c04000c, 32'h00832822, 32'hac05000c, 32'h20060001,
                               32'h00c63020, 32'h1000ffff, 32'hac260010};
   logic [31:0] exp_pc [14] = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h08, 32'h0C, 32'h10,
                                32'h14, 32'h18, 32'h1C, 32'h20, 32'h14, 32'h14, 32'h10};
   logic [31:0] exp_csum;
   logic [7:0]  next_addr;
   int          n_wr;

   initial begin
      rst_n = 1'b0;
      {load_start, run_start, halt_req, load_valid, load_last, branch_taken, stall} = '0;
      load_data = '0;
      branch_target = '0;
      #12;
      check("rst_state", state, 0);
      check("rst_pc", pc, 0);
      check("rst_count", load_count, 0);
      check("rst_err", load_err, 0);
      check("rst_csum", load_csum, 0);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_load_ready", load_ready, 0);
      check("rst_we", imem_we, 0);
      rst_n = 1'b1;
      cyc();

      // 11-word load with valid held high
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      check("load_entry_state", state, 1);
      check("load_entry_ready", load_ready, 1);
      for (int i = 0; i < 11; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         load_last  = (i == 10);
         #1;
         check("load_we", imem_we, 1);
         check("load_waddr", imem_waddr, i);
         check("load_wdata", imem_wdata, words[i]);
         cyc();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("load_count11", load_count, 11);
      check("load_done_state", state, 2);
      check("load_done_pc", pc, 0);
      check("load_done_fetch_valid", fetch_valid, 1);
      exp_csum = 32'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      for (int i = 0; i < 11; i++) exp_csum = exp_csum ^ words[i];
`endif
      check("load_csum", load_csum, exp_csum);

      // PC sequencing: stall, branch, stall-over-branch, halt-over-branch
      for (int k = 0; k < 14; k++) begin
         check("run_pc", pc, exp_pc[k]);
         stall         = (k == 2 || k == 3 || k == 11);
         branch_taken  = (k >= 10);
         branch_target = (k == 12) ? 32'h10 : (k == 13) ? 32'h40 : 32'h17;
         halt_req      = (k == 13);
         cyc();
      end
      {stall, branch_taken, halt_req} = '0;
      check("halt_state", state, 3);
      check("halt_pc", pc, 32'h10);
      check("halt_fetch_valid", fetch_valid, 0);
      cyc();
      check("halt_hold_pc", pc, 32'h10);
      check("halt_hold_state", state, 3);
      run_start = 1'b1;
      cyc();
      run_start = 1'b0;
      check("resume_state", state, 2);
      check("resume_pc", pc, 32'h10);
      cyc();
      check("resume_pc_next", pc, 32'h14);

      // Re-load abort from RUN with a throttled loader
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      check("reload_state", state, 1);
      check("reload_pc", pc, 0);
      check("reload_count", load_count, 0);
      next_addr = 8'd0;
      n_wr = 0;
      for (int k = 0; k < 7; k++) begin
         load_valid = (k % 2 == 0);
         load_data  = 32'h1000 + k;
         load_last  = (k == 6);
         #1;
         check("thr_we", imem_we, load_valid);
         if (load_valid) begin
            check("thr_waddr", imem_waddr, next_addr);
            check("thr_wdata", imem_wdata, 32'h1000 + k);
            next_addr++;
         end
         if (imem_we) n_wr++;
         cyc();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("thr_writes", n_wr, 4);
      check("thr_count", load_count, 4);
      check("thr_state", state, 2);

      // Overflow: DEPTH transfers without load_last
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         load_valid = 1'b1;
         load_data  = i;
         #1;
         check("ovf_we", imem_we, 1);
         check("ovf_waddr", imem_waddr, i);
         cyc();
      end
      #1;
      check("ovf_err", load_err, 1);
      check("ovf_state", state, 0);
      check("ovf_count", load_count, 256);
      check("ovf_no_wrap_we", imem_we, 0);
      check("ovf_waddr_idle", imem_waddr, 0);
      check("ovf_wdata_idle", imem_wdata, 0);
      load_valid = 1'b0;

      // Asynchronous reset in the middle of a load
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      check("rl_err_cleared", load_err, 0);
      load_valid = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      check("rl_count5", load_count, 5);
      #2;
      rst_n = 1'b0;
      #1;
      check("rl_state", state, 0);
      check("rl_count", load_count, 0);
      check("rl_we", imem_we, 0);
      check("rl_ready", load_ready, 0);
      check("rl_pc", pc, 0);
      check("rl_csum", load_csum, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("post_rst_state", state, 0);
      check("post_rst_we", imem_we, 0);
      load_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
